// File: rtl/lfsr_prng_gen_if.sv
// Handshake/bus bundle between the LFSR generator and its consumer.
// The consumer side (master) drives the advance/reseed controls; the generator
// side (slave) returns the registered result, status flags and period length.
interface lfsr_prng_gen_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             enable_i;
    logic             ready_i;
    logic             load_i;
    logic [WIDTH-1:0] seed_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             lockup_o;
    logic             period_o;
    logic [WIDTH-1:0] period_len_o;

    modport master (
        output enable_i, ready_i, load_i, seed_i,
        input  valid_o, result_o, lockup_o, period_o, period_len_o
    );

    modport slave (
        input  enable_i, ready_i, load_i, seed_i,
        output valid_o, result_o, lockup_o, period_o, period_len_o
    );
endinterface

// File: rtl/lfsr_prng_gen.sv
// Parametrised LFSR pseudo-random generator (Fibonacci or Galois form) with
// run-time reseed, zero-lockup protection, valid/ready output handshake and
// a period-length counter measured against the most recent (re)seed value.
module lfsr_prng_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001,
    parameter bit               MODE  = 1'b1,
    parameter int unsigned      STEPS = 1
) (
    input  logic           clock_i,
    input  logic           reset_i,
    lfsr_prng_gen_if.slave prng
);

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             SEED_ZERO = (SEED == {WIDTH{1'b0}});
    // An all-zero state would lock the register up, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_FIX  = SEED_ZERO ? ONE : SEED;

    // RESET: held while reset_i is high; the following edge enters RUN.
    // PRIME: the single cycle after a reseed in which the result is not valid.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } fsm_t;

    fsm_t             r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period_len;
    logic             r_valid;
    logic             r_lockup;
    logic             r_period;

    logic [WIDTH-1:0] w_stepped;
    logic [WIDTH-1:0] w_seed_fix;
    logic             w_seed_zero;
    logic             w_advance;
    logic             w_count_sat;
    logic             w_ref_hit;
    logic [WIDTH-1:0] w_count_inc;

    // Even/odd parity of the tapped stages (Fibonacci feedback bit).
    function automatic logic fb_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // One LFSR shift in the configured form.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        if (MODE == 1'b1) begin
            if (s[0] == 1'b1) begin
                n = (s >> 1) ^ TAPS;
            end else begin
                n = s >> 1;
            end
        end else begin
            n = {s[WIDTH-2:0], fb_parity(s & TAPS)};
        end
        return n;
    endfunction

    // STEPS single shifts chained combinationally, plus advance/period decode.
    always_comb begin
        w_stepped = r_state;
        for (int unsigned i = 0; i < STEPS; i++) begin
            w_stepped = lfsr_step(w_stepped);
        end
        w_seed_zero = (prng.seed_i == {WIDTH{1'b0}});
        if (w_seed_zero) begin
            w_seed_fix = ONE;
        end else begin
            w_seed_fix = prng.seed_i;
        end
        w_advance   = prng.enable_i & r_valid & prng.ready_i & ~prng.load_i;
        w_count_sat = &r_count;
        w_ref_hit   = (w_stepped == r_ref);
        w_count_inc = r_count + ONE;
    end

    // Control FSM, LFSR state, period tracking and registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fsm        <= ST_RESET;
            r_state      <= SEED_FIX;
            r_ref        <= SEED_FIX;
            r_count      <= {WIDTH{1'b0}};
            r_period_len <= {WIDTH{1'b0}};
            r_valid      <= 1'b0;
            r_lockup     <= SEED_ZERO;
            r_period     <= 1'b0;
        end else begin
            r_period <= 1'b0;
            if (prng.load_i) begin
                // Reseed wins over advance and restarts period measurement.
                r_fsm   <= ST_PRIME;
                r_state <= w_seed_fix;
                r_ref   <= w_seed_fix;
                r_count <= {WIDTH{1'b0}};
                r_valid <= 1'b0;
                if (w_seed_zero) begin
                    r_lockup <= 1'b1;
                end else begin
                    r_lockup <= r_lockup;
                end
            end else begin
                case (r_fsm)
                    ST_RESET, ST_PRIME, ST_RUN: begin
                        r_fsm   <= ST_RUN;
                        r_valid <= 1'b1;
                    end
                    default: begin
                        r_fsm   <= ST_RESET;
                        r_valid <= 1'b0;
                    end
                endcase
                if (w_advance) begin
                    r_state <= w_stepped;
                    if (w_count_sat) begin
                        // Saturated count is meaningless: no pulse, just restart.
                        if (w_ref_hit) begin
                            r_count <= {WIDTH{1'b0}};
                        end else begin
                            r_count <= r_count;
                        end
                    end else if (w_ref_hit) begin
                        r_period     <= 1'b1;
                        r_period_len <= w_count_inc;
                        r_count      <= {WIDTH{1'b0}};
                    end else begin
                        r_count <= w_count_inc;
                    end
                end else begin
                    r_state <= r_state;
                    r_count <= r_count;
                end
            end
        end
    end

    assign prng.valid_o      = r_valid;
    assign prng.result_o     = r_state;
    assign prng.lockup_o     = r_lockup;
    assign prng.period_o     = r_period;
    assign prng.period_len_o = r_period_len;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Self-checking bench for lfsr_prng_gen: five configurations share one
// stimulus stream; a directed vector table covers the documented sequences
// and a randomized run is checked every cycle against a behavioural model.
module tb_lfsr_prng_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, rdy, ld;
    logic [15:0] seed;

    always #5 clk = ~clk;

    // Configs: 0 Galois W4, 1 Fibonacci W4, 2 Galois W4 STEPS=4,
    //          3 default W16, 4 Fibonacci W5 SEED=0 STEPS=3
    lfsr_prng_gen_if #(.WIDTH(4))  if_a ();
    lfsr_prng_gen_if #(.WIDTH(4))  if_b ();
    lfsr_prng_gen_if #(.WIDTH(4))  if_c ();
    lfsr_prng_gen_if #(.WIDTH(16)) if_d ();
    lfsr_prng_gen_if #(.WIDTH(5))  if_e ();

    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1'b1), .STEPS(1))
        u_a (.clock_i(clk), .reset_i(rst), .prng(if_a));
    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1'b0), .STEPS(1))
        u_b (.clock_i(clk), .reset_i(rst), .prng(if_b));
    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1'b1), .STEPS(4))
        u_c (.clock_i(clk), .reset_i(rst), .prng(if_c));
    lfsr_prng_gen #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .MODE(1'b1), .STEPS(1))
        u_d (.clock_i(clk), .reset_i(rst), .prng(if_d));
    lfsr_prng_gen #(.WIDTH(5), .TAPS(5'h14), .SEED(5'h00), .MODE(1'b0), .STEPS(3))
        u_e (.clock_i(clk), .reset_i(rst), .prng(if_e));

    assign if_a.enable_i = en;  assign if_a.ready_i = rdy;  assign if_a.load_i = ld;  assign if_a.seed_i = seed[3:0];
    assign if_b.enable_i = en;  assign if_b.ready_i = rdy;  assign if_b.load_i = ld;  assign if_b.seed_i = seed[3:0];
    assign if_c.enable_i = en;  assign if_c.ready_i = rdy;  assign if_c.load_i = ld;  assign if_c.seed_i = seed[3:0];
    assign if_d.enable_i = en;  assign if_d.ready_i = rdy;  assign if_d.load_i = ld;  assign if_d.seed_i = seed;
    assign if_e.enable_i = en;  assign if_e.ready_i = rdy;  assign if_e.load_i = ld;  assign if_e.seed_i = seed[4:0];

    logic [15:0] o_res [5];
    logic [15:0] o_len [5];
    logic        o_val [5];
    logic        o_lck [5];
    logic        o_per [5];

    assign o_res[0] = {12'd0, if_a.result_o}; assign o_len[0] = {12'd0, if_a.period_len_o};
    assign o_res[1] = {12'd0, if_b.result_o}; assign o_len[1] = {12'd0, if_b.period_len_o};
    assign o_res[2] = {12'd0, if_c.result_o}; assign o_len[2] = {12'd0, if_c.period_len_o};
    assign o_res[3] = if_d.result_o;          assign o_len[3] = if_d.period_len_o;
    assign o_res[4] = {11'd0, if_e.result_o}; assign o_len[4] = {11'd0, if_e.period_len_o};
    assign o_val[0] = if_a.valid_o; assign o_lck[0] = if_a.lockup_o; assign o_per[0] = if_a.period_o;
    assign o_val[1] = if_b.valid_o; assign o_lck[1] = if_b.lockup_o; assign o_per[1] = if_b.period_o;
    assign o_val[2] = if_c.valid_o; assign o_lck[2] = if_c.lockup_o; assign o_per[2] = if_c.period_o;
    assign o_val[3] = if_d.valid_o; assign o_lck[3] = if_d.lockup_o; assign o_per[3] = if_d.period_o;
    assign o_val[4] = if_e.valid_o; assign o_lck[4] = if_e.lockup_o; assign o_per[4] = if_e.period_o;

    // Configuration as seen by the reference model.
    int p_w     [5] = '{4, 4, 4, 16, 5};
    int p_taps  [5] = '{'hC, 'hC, 'hC, 'hB400, 'h14};
    int p_seed  [5] = '{1, 1, 1, 1, 0};
    int p_mode  [5] = '{1, 0, 1, 1, 0};
    int p_steps [5] = '{1, 1, 4, 1, 3};

    // Reference model state.
    int m_state [5];
    int m_ref   [5];
    int m_cnt   [5];
    int m_len   [5];
    bit m_valid [5];
    bit m_lock  [5];
    bit m_per   [5];

    int n_checks = 0;
    int n_fail   = 0;

    // Polynomial view of one shift: Galois divides by x and folds the taps
    // back in on a carry-out; Fibonacci doubles and appends the tap parity.
    function automatic int model_step(int k, int s);
        if (p_mode[k] == 1) begin
            return (s / 2) ^ ((s % 2) * p_taps[k]);
        end
        return (s * 2 + ($countones(s & p_taps[k]) % 2)) % (1 << p_w[k]);
    endfunction

    task automatic model_clock();
        for (int k = 0; k < 5; k++) begin
            int mask;
            int nxt;
            int s;
            bit adv;
            mask = (1 << p_w[k]) - 1;
            if (rst) begin
                s = (p_seed[k] == 0) ? 1 : p_seed[k];
                m_state[k] = s; m_ref[k] = s; m_cnt[k] = 0; m_len[k] = 0;
                m_valid[k] = 1'b0; m_per[k] = 1'b0; m_lock[k] = (p_seed[k] == 0);
            end else if (ld) begin
                s = int'(seed) & mask;
                if (s == 0) begin
                    s = 1;
                    m_lock[k] = 1'b1;
                end
                m_state[k] = s; m_ref[k] = s; m_cnt[k] = 0;
                m_valid[k] = 1'b0; m_per[k] = 1'b0;
            end else begin
                adv = en && rdy && m_valid[k];
                m_per[k] = 1'b0;
                m_valid[k] = 1'b1;
                if (adv) begin
                    nxt = m_state[k];
                    repeat (p_steps[k]) nxt = model_step(k, nxt);
                    if (m_cnt[k] == mask) begin
                        if (nxt == m_ref[k]) m_cnt[k] = 0;
                    end else if (nxt == m_ref[k]) begin
                        m_per[k] = 1'b1; m_len[k] = m_cnt[k] + 1; m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                    m_state[k] = nxt;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("model.result[%0d]", k), {16'd0, o_res[k]}, m_state[k]);
            chk($sformatf("model.valid[%0d]", k),  {31'd0, o_val[k]}, {31'd0, m_valid[k]});
            chk($sformatf("model.lockup[%0d]", k), {31'd0, o_lck[k]}, {31'd0, m_lock[k]});
            chk($sformatf("model.period[%0d]", k), {31'd0, o_per[k]}, {31'd0, m_per[k]});
            chk($sformatf("model.len[%0d]", k),    {16'd0, o_len[k]}, m_len[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    typedef struct {
        logic       en, rdy, ld;
        logic [3:0] seed;
        logic [3:0] ea, eb, ec;
        logic       ev, el, ep;
        logic [3:0] elen;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic r, input logic l, input logic [3:0] sd,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic v, input logic lk, input logic p, input logic [3:0] len);
        vec_t t;
        t.en = e; t.rdy = r; t.ld = l; t.seed = sd;
        t.ea = a; t.eb = b; t.ec = c; t.ev = v; t.el = lk; t.ep = p; t.elen = len;
        tbl.push_back(t);
    endtask

    logic [3:0] seq_a [16] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    logic [3:0] seq_b [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] seq_c [16] = '{4'h1, 4'hD, 4'h7, 4'h8, 4'hC, 4'hA, 4'hF, 4'h4,
                               4'h6, 4'h5, 4'hB, 4'h2, 4'h3, 4'hE, 4'h9, 4'h1};

    initial begin
        rst = 1'b1; en = 1'b0; rdy = 1'b0; ld = 1'b0; seed = 16'h0000;

        // Directed vectors for the three 4-bit configurations.
        add(1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 15; i++) begin
            add(1'b1, 1'b1, 1'b0, 4'h0, seq_a[i], seq_b[i], seq_c[i],
                1'b1, 1'b0, (i == 15), (i == 15) ? 4'd15 : 4'd0);
        end
        add(1'b1, 1'b1, 1'b0, 4'h0, 4'hC, 4'h2, 4'hD, 1'b1, 1'b0, 1'b0, 4'd15);
        for (int i = 0; i < 5; i++) begin
            add(1'b1, 1'b0, 1'b0, 4'h0, 4'hC, 4'h2, 4'hD, 1'b1, 1'b0, 1'b0, 4'd15);
        end
        add(1'b1, 1'b1, 1'b0, 4'h0, 4'h6, 4'h4, 4'h7, 1'b1, 1'b0, 1'b0, 4'd15);
        add(1'b0, 1'b1, 1'b0, 4'h0, 4'h6, 4'h4, 4'h7, 1'b1, 1'b0, 1'b0, 4'd15);
        add(1'b1, 1'b1, 1'b1, 4'h0, 4'h1, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 4'd15);
        add(1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 4'd15);
        add(1'b1, 1'b1, 1'b0, 4'h0, 4'hC, 4'h2, 4'hD, 1'b1, 1'b1, 1'b0, 4'd15);
        add(1'b0, 1'b1, 1'b1, 4'h5, 4'h5, 4'h5, 4'h5, 1'b0, 1'b1, 1'b0, 4'd15);
        add(1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0, 4'd15);
        add(1'b1, 1'b1, 1'b0, 4'h5, 4'hE, 4'hB, 4'hB, 1'b1, 1'b1, 1'b0, 4'd15);

        // Reset state.
        tick();
        chk("reset.result_a", {28'd0, if_a.result_o}, 32'h1);
        chk("reset.valid_a",  {31'd0, if_a.valid_o}, 32'h0);
        chk("reset.len_a",    {28'd0, if_a.period_len_o}, 32'h0);
        chk("reset.lockup_a", {31'd0, if_a.lockup_o}, 32'h0);
        chk("reset.result_e", {27'd0, if_e.result_o}, 32'h1);
        chk("reset.lockup_e", {31'd0, if_e.lockup_o}, 32'h1);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            en = tbl[i].en; rdy = tbl[i].rdy; ld = tbl[i].ld; seed = {12'd0, tbl[i].seed};
            tick();
            chk($sformatf("vec%0d.result_a", i), {28'd0, if_a.result_o}, {28'd0, tbl[i].ea});
            chk($sformatf("vec%0d.result_b", i), {28'd0, if_b.result_o}, {28'd0, tbl[i].eb});
            chk($sformatf("vec%0d.result_c", i), {28'd0, if_c.result_o}, {28'd0, tbl[i].ec});
            chk($sformatf("vec%0d.valid", i),    {31'd0, if_a.valid_o},  {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d.lockup", i),   {31'd0, if_a.lockup_o}, {31'd0, tbl[i].el});
            chk($sformatf("vec%0d.period", i),   {31'd0, if_c.period_o}, {31'd0, tbl[i].ep});
            chk($sformatf("vec%0d.len", i),      {28'd0, if_b.period_len_o}, {28'd0, tbl[i].elen});
            #1;
        end

        // Reset in the middle of a period discards state, count and lockup.
        en = 1'b1; rdy = 1'b1; ld = 1'b0;
        repeat (3) begin
            tick();
            #1;
        end
        rst = 1'b1;
        tick();
        chk("midreset.result_a", {28'd0, if_a.result_o}, 32'h1);
        chk("midreset.valid_a",  {31'd0, if_a.valid_o}, 32'h0);
        chk("midreset.len_a",    {28'd0, if_a.period_len_o}, 32'h0);
        chk("midreset.lockup_a", {31'd0, if_a.lockup_o}, 32'h0);
        chk("midreset.result_d", {16'd0, if_d.result_o}, 32'h1);
        #1 rst = 1'b0;

        // Randomized traffic checked against the model every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en   = ($urandom_range(0, 99) < 85);
            rdy  = ($urandom_range(0, 99) < 80);
            ld   = ($urandom_range(0, 199) < 3);
            seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rst  = ($urandom_range(0, 999) < 4);
            tick();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
